// File: rtl/tt_um_instruction_fetch_if.sv
// Byte-wide pin bundle between the instruction fetch unit and its environment
// (control inputs, memory data/jump target, address/status and instruction outputs).
interface tt_um_instruction_fetch_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport slave (
      input  ui_in,
      input  uio_in,
      output uo_out,
      output uio_out,
      output uio_oe
   );

   modport master (
      output ui_in,
      output uio_in,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );
endinterface

// File: rtl/tt_um_instruction_fetch.sv
// Fetches 16-bit instructions as two bytes from external byte memory and hands them downstream
// as two beats. Optional IFETCH_SKIP_NOP_EN drops all-zero instructions instead of presenting them.
module tt_um_instruction_fetch (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   tt_um_instruction_fetch_if.slave  bus
);

   localparam int unsigned PC_W   = 6;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH_HI = 3'd1,
      FETCH_LO = 3'd2,
      SEND_HI  = 3'd3,
      SEND_LO  = 3'd4
   } state_t;

   state_t              state, state_n;
   logic [PC_W-1:0]     pc, pc_n;
   logic [BYTE_W-1:0]   hi, hi_n, lo, lo_n;
   logic [BYTE_W-1:0]   uo_out_q, uio_out_q, uio_oe_q;

   logic mem_ack, ir_ready, jump, stall;
   logic fetch_n, send_n;
   logic [3:0] unused_ui;

   assign mem_ack   = bus.ui_in[0];
   assign ir_ready  = bus.ui_in[1];
   assign jump      = bus.ui_in[2];
   assign stall     = bus.ui_in[3];
   assign unused_ui = bus.ui_in[7:4];

   assign bus.uo_out  = uo_out_q;
   assign bus.uio_out = uio_out_q;
   assign bus.uio_oe  = uio_oe_q;

   // Next state, PC and byte registers; a jump always wins over a memory ack.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      hi_n    = hi;
      lo_n    = lo;
      case (state)
         IDLE: state_n = FETCH_HI;
         FETCH_HI, FETCH_LO: begin
            if (jump) begin
               pc_n    = {bus.uio_in[5:1], 1'b0};
               state_n = FETCH_HI;
            end else if (mem_ack && !stall) begin
               pc_n = pc + PC_W'(1);
               if (state == FETCH_HI) begin
                  hi_n    = bus.uio_in;
                  state_n = FETCH_LO;
               end else begin
                  lo_n    = bus.uio_in;
                  state_n = SEND_HI;
`ifdef IFETCH_SKIP_NOP_EN
                  if (hi == 8'h00 && bus.uio_in == 8'h00) state_n = FETCH_HI;
`endif
               end
            end
         end
         SEND_HI: if (ir_ready) state_n = SEND_LO;
         SEND_LO: if (ir_ready) state_n = FETCH_HI;
         default: state_n = IDLE;
      endcase
   end

   assign fetch_n = (state_n == FETCH_HI) || (state_n == FETCH_LO);
   assign send_n  = (state_n == SEND_HI)  || (state_n == SEND_LO);

   // State and registered pin outputs, all frozen while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= '0;
         hi        <= '0;
         lo        <= '0;
         uo_out_q  <= '0;
         uio_out_q <= '0;
         uio_oe_q  <= '0;
      end else if (ena) begin
         state     <= state_n;
         pc        <= pc_n;
         hi        <= hi_n;
         lo        <= lo_n;
         uo_out_q  <= {send_n, fetch_n & ~stall, pc_n};
         uio_oe_q  <= send_n ? 8'hFF : 8'h00;
         if (state_n == SEND_HI)      uio_out_q <= hi_n;
         else if (state_n == SEND_LO) uio_out_q <= lo_n;
         else                         uio_out_q <= 8'h00;
      end
   end

endmodule

// File: tb/tb_tt_um_instruction_fetch.sv
// Self-checking bench for tt_um_instruction_fetch: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_tt_um_instruction_fetch;

`ifdef IFETCH_SKIP_NOP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk, rst_n, ena;
   tt_um_instruction_fetch_if bus ();

   tt_um_instruction_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   logic [7:0] mem [64];

   // Model: current instruction as bytes fetched so far / beats sent so far.
   bit         m_started;
   int         m_pc;
   int         m_nb;
   int         m_ns;
   logic [7:0] m_b [2];
   bit         m_req;

   function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_started = 1'b0;
      m_pc      = 0;
      m_nb      = 0;
      m_ns      = 0;
      m_b[0]    = 8'h00;
      m_b[1]    = 8'h00;
      m_req     = 1'b0;
   endfunction

   function automatic void model_edge(input logic [7:0] ui, input logic [7:0] d);
      bit ack, rdy, jmp, stl;
      ack = ui[0]; rdy = ui[1]; jmp = ui[2]; stl = ui[3];
      if (!m_started) begin
         m_started = 1'b1;
      end else if (m_nb < 2) begin
         if (jmp) begin
            m_pc = int'(d & 8'h3E);
            m_nb = 0;
         end else if (ack && !stl) begin
            m_b[m_nb] = d;
            m_nb++;
            m_pc = (m_pc + 1) % 64;
            if (m_nb == 2 && SKIP && m_b[0] == 8'h00 && m_b[1] == 8'h00) m_nb = 0;
         end
      end else if (rdy) begin
         m_ns++;
         if (m_ns == 2) begin
            m_ns = 0;
            m_nb = 0;
         end
      end
      m_req = m_started && (m_nb < 2) && !stl;
   endfunction

   function automatic logic [7:0] exp_uo();
      logic [5:0] a;
      a = 6'(m_pc);
      return {(m_nb == 2), m_req, a};
   endfunction

   function automatic logic [7:0] exp_data();
      return (m_nb == 2) ? m_b[m_ns] : 8'h00;
   endfunction

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("uo_out", bus.uo_out, exp_uo());
         chk("uio_out", bus.uio_out, exp_data());
         chk("uio_oe", bus.uio_oe, (m_nb == 2) ? 8'hFF : 8'h00);
      end
   end

   task automatic tick(input bit e, input bit ack, input bit rdy, input bit jmp, input bit stl,
                       input logic [7:0] jdata);
      #1;
      ena        = e;
      bus.ui_in  = {4'($urandom), stl, jmp, rdy, ack};
      if (jmp)                       bus.uio_in = jdata;
      else if (m_started && m_nb < 2) bus.uio_in = mem[m_pc];
      else                           bus.uio_in = 8'($urandom);
      if (e) model_edge(bus.ui_in, bus.uio_in);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_uo_out", bus.uo_out, 8'h00);
      chk("rst_uio_out", bus.uio_out, 8'h00);
      chk("rst_uio_oe", bus.uio_oe, 8'h00);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] first_beat;
      bit         seen;

      rst_n      = 1'b0;
      ena        = 1'b0;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(1, 255));
      model_reset();
      @(negedge clk);
      cmp_en = 1'b1;

      // Reset, basic fetch, backpressure and ena freeze.
      mem[0] = 8'h12; mem[1] = 8'h34;
      do_reset();
      tick(1, 1, 0, 0, 0, 8'h00);
      chk("reset_release", bus.uo_out, 8'h40);
      tick(1, 1, 0, 0, 0, 8'h00);
      chk("fetch_lo_addr", bus.uo_out, 8'h41);
      tick(1, 1, 0, 0, 0, 8'h00);
      chk("send_hi_data", bus.uio_out, 8'h12);
      chk("send_hi_valid", {7'h0, bus.uo_out[7]}, 8'h01);
      chk("send_hi_oe", bus.uio_oe, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         tick(1, 1, 0, 1, 0, 8'h3F);
         chk("bp_hold_data", bus.uio_out, 8'h12);
         chk("bp_hold_valid", {7'h0, bus.uo_out[7]}, 8'h01);
      end
      tick(0, 1, 1, 0, 0, 8'h00);
      tick(0, 1, 1, 0, 0, 8'h00);
      chk("ena_freeze", bus.uio_out, 8'h12);
      tick(1, 1, 1, 0, 0, 8'h00);
      chk("send_lo_data", bus.uio_out, 8'h34);
      tick(1, 1, 1, 0, 0, 8'h00);
      chk("next_fetch_addr", bus.uo_out, 8'h42);

      // Jump from FETCH_LO discards the partial instruction.
      do_reset();
      tick(1, 1, 0, 0, 0, 8'h00);
      tick(1, 1, 0, 0, 0, 8'h00);
      chk("pre_jump_addr", bus.uo_out, 8'h41);
      tick(1, 1, 0, 1, 0, 8'h2B);
      chk("jump_target", bus.uo_out, 8'h6A);
      tick(1, 1, 0, 0, 0, 8'h00);
      chk("after_jump_no_beat", bus.uo_out, 8'h6B);

      // Wrap at 63 with a stalled fetch at 62.
      mem[62] = 8'h5A; mem[63] = 8'hA5;
      tick(1, 1, 0, 1, 0, 8'h3E);
      chk("jump_to_62", bus.uo_out, 8'h7E);
      for (int i = 0; i < 3; i++) begin
         tick(1, 1, 0, 0, 1, 8'h00);
         chk("stall_no_req", bus.uo_out, 8'h3E);
      end
      tick(1, 1, 0, 0, 0, 8'h00);
      chk("fetch_63", bus.uo_out, 8'h7F);
      tick(1, 1, 0, 0, 0, 8'h00);
      chk("wrap_send_hi", bus.uio_out, 8'h5A);
      chk("wrap_pc_zero", bus.uo_out, 8'h80);
      tick(1, 1, 1, 0, 0, 8'h00);
      chk("wrap_send_lo", bus.uio_out, 8'hA5);
      tick(1, 1, 1, 0, 0, 8'h00);
      chk("wrap_next_fetch", bus.uo_out, 8'h40);

      // All-zero instruction: skipped or presented depending on build.
      mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hAB; mem[3] = 8'hCD;
      do_reset();
      seen       = 1'b0;
      first_beat = 8'hEE;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1, 1, 1, 0, 0, 8'h00);
         if (bus.uo_out[7]) begin
            seen       = 1'b1;
            first_beat = bus.uio_out;
         end
      end
      if (!seen) chk("nop_timeout", 8'h00, 8'h01);
      else       chk("nop_first_beat", first_beat, SKIP ? 8'hAB : 8'h00);

      // Randomized traffic including mid-flight resets.
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         int a;
         a = 2 * $urandom_range(0, 31);
         mem[a] = 8'h00; mem[a + 1] = 8'h00;
      end
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, 8'($urandom));
      end

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
